// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2-input FP32 max-pooling forward/backward pair.
// Both ends import this package so the winner-select encoding cannot drift.
package maxpool_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic {
    SEL_IN1 = 1'b0,
    SEL_IN2 = 1'b1
  } pool_sel_t;

  // Occupancy view of the index FIFO.
  typedef enum logic [1:0] {
    FIFO_EMPTY  = 2'd0,
    FIFO_ACTIVE = 2'd1,
    FIFO_FULL   = 2'd2
  } fifo_state_t;

  // Output register view.
  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_HOLD = 1'b1
  } out_state_t;

endpackage

// File: rtl/maxpool_bwd_2_idx_fifo.sv
// Select-bit FIFO (DEPTH x 1) holding forward-pass winners until the matching
// gradient arrives. flush has priority over push and pop.
module idx_fifo
  import maxpool_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  pool_sel_t        sel_i,
  input  logic             pop_i,
  output pool_sel_t        sel_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != FULL_CNT) && !flush_i;
  assign pop_ok  = pop_i && (count_q != '0) && !flush_i;
  assign sel_o   = pool_sel_t'(mem_q[rd_ptr_q]);
  assign count_o = count_q;

  // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= sel_i;
  end

endmodule

// File: rtl/maxpool_bwd_2.sv
// Backward max-pool gradient router: each upstream gradient pops one stored
// winner-select bit and is steered to the winning lane, the other lane gets +0.0.
//
// state       | meaning
// ------------+-----------------------------------------------
// FIFO_EMPTY  | no select bits stored, gradients stall
// FIFO_ACTIVE | 0 < count < DEPTH, push and pop both allowed
// FIFO_FULL   | count == DEPTH, pushes refused
// OUT_IDLE    | output register empty
// OUT_HOLD    | pair presented, held until out_ready
module maxpool_bwd_2
  import maxpool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              idx_valid,
  input  logic              idx_sel,
  output logic              idx_ready,
  input  logic              grad_valid,
  input  logic [DATA_W-1:0] grad_in,
  output logic              grad_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] grad_out1,
  output logic [DATA_W-1:0] grad_out2,
  output logic [CNT_W-1:0]  idx_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fifo_state_t       fifo_st;
  out_state_t        out_st;
  pool_sel_t         head_sel;
  logic              push, accept;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] grad1_q, grad1_d;
  logic [DATA_W-1:0] grad2_q, grad2_d;

  idx_fifo #(.DEPTH(DEPTH)) u_idx_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .sel_i   (pool_sel_t'(idx_sel)),
    .pop_i   (accept),
    .sel_o   (head_sel),
    .count_o (idx_count)
  );

  // Controller state decoded from occupancy and the output register.
  always_comb begin
    fifo_st = FIFO_ACTIVE;
    if (idx_count == '0)           fifo_st = FIFO_EMPTY;
    else if (idx_count == FULL_CNT) fifo_st = FIFO_FULL;
    out_st = out_valid_q ? OUT_HOLD : OUT_IDLE;
  end

  // Handshakes; a full FIFO refuses pushes even when a pop happens the same cycle.
  assign idx_ready  = (fifo_st != FIFO_FULL);
  assign grad_ready = (fifo_st != FIFO_EMPTY) && ((out_st == OUT_IDLE) || out_ready);
  assign push       = idx_valid && idx_ready;
  assign accept     = grad_valid && grad_ready && !flush;

  // Output stage next state: load on accept, drain on out_ready, flush clears valid only.
  always_comb begin
    out_valid_d = out_valid_q;
    grad1_d     = grad1_q;
    grad2_d     = grad2_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      grad1_d     = (head_sel == SEL_IN1) ? grad_in : '0;
      grad2_d     = (head_sel == SEL_IN2) ? grad_in : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; words pass bit-exact, zero lane is +0.0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      grad1_q     <= '0;
      grad2_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      grad1_q     <= grad1_d;
      grad2_q     <= grad2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign grad_out1 = grad1_q;
  assign grad_out2 = grad2_q;

endmodule

// File: tb/tb_maxpool_bwd_2.sv
module tb_maxpool_bwd_2;

  logic        clk = 1'b0;
  logic        rst, flush, idx_valid, idx_sel, grad_valid, out_ready;
  logic [31:0] grad_in;
  logic        idx_ready, grad_ready, out_valid;
  logic [31:0] grad_out1, grad_out2;
  logic [4:0]  idx_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic        sel_model[$];

  maxpool_bwd_2 #(.DATA_W(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .idx_valid(idx_valid), .idx_sel(idx_sel), .idx_ready(idx_ready),
    .grad_valid(grad_valid), .grad_in(grad_in), .grad_ready(grad_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .grad_out1(grad_out1), .grad_out2(grad_out2), .idx_count(idx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pair taken downstream is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pair: got %h_%h, expected no output", grad_out1, grad_out2);
      end else begin
        check("pair", {grad_out1, grad_out2}, exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus; handshakes sampled at the falling edge before the accepting edge.
  task automatic cycle(input logic pv, input logic ps, input logic gv, input logic [31:0] gd,
                       output logic g_acc, output logic p_acc);
    logic s;
    idx_valid  = pv;
    idx_sel    = ps;
    grad_valid = gv;
    grad_in    = gd;
    @(negedge clk);
    p_acc = pv && idx_ready;
    g_acc = gv && grad_ready;
    if (g_acc) begin
      if (sel_model.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL grad_ready_empty: got 1, expected 0");
      end else begin
        s = sel_model.pop_front();
        exp_q.push_back(s ? {32'h0, gd} : {gd, 32'h0});
      end
    end
    if (p_acc) sel_model.push_back(ps);
    @(posedge clk);
    #1;
    idx_valid  = 1'b0;
    grad_valid = 1'b0;
  endtask

  task automatic idle();
    logic ga, pa;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, ga, pa);
  endtask

  task automatic push_bit(input logic s);
    logic ga, pa;
    cycle(1'b1, s, 1'b0, 32'h0, ga, pa);
  endtask

  task automatic send_grad(input logic [31:0] d);
    logic ga, pa;
    int   n = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b1, d, ga, pa);
      n++;
    end while (!ga && n < 40);
    if (!ga) begin
      n_tests++;
      n_fail++;
      $display("FAIL grad_timeout: got no accept, expected accept within 40 cycles");
    end else begin
      check("latency_valid", out_valid, 1'b1);
    end
  endtask

  initial begin
    logic ga, pa;
    logic [31:0] vec[4];
    rst = 1'b1; flush = 1'b0; idx_valid = 1'b0; idx_sel = 1'b0;
    grad_valid = 1'b0; grad_in = '0; out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_idx_ready", idx_ready, 1'b1);
    check("rst_grad_ready", grad_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outs", {grad_out1, grad_out2}, 64'h0);
    check("rst_count", idx_count, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic routing, including NaN payload preservation
    push_bit(1'b0); push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
    check("count4", idx_count, 5'd4);
    vec[0] = 32'h3F80_0000; vec[1] = 32'h4000_0000;
    vec[2] = 32'hC040_0000; vec[3] = 32'h7FC0_0001;
    for (int i = 0; i < 4; i++) send_grad(vec[i]);
    idle();
    check("count_end_basic", idx_count, 5'd0);

    // Fill to 17: 17th refused
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, logic'((i % 3) == 1), 1'b0, 32'h0, ga, pa);
      if (i == 15) begin
        check("full_count", idx_count, 5'd16);
        check("full_idx_ready", idx_ready, 1'b0);
      end
      if (i == 16) check("push17_refused", pa, 1'b0);
    end
    check("full_count_after17", idx_count, 5'd16);
    for (int i = 0; i < 16; i++) send_grad(32'h4100_0000 + i);
    idle();
    check("drained_count", idx_count, 5'd0);
    // Second fill crosses the pointer wrap point
    for (int i = 0; i < 12; i++) push_bit(logic'(i[1]));
    for (int i = 0; i < 12; i++) send_grad(32'h8000_0000 + i);
    idle();
    check("wrap_count", idx_count, 5'd0);

    // Backpressure
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
    out_ready = 1'b0;
    send_grad(32'h3F00_0000);
    repeat (3) idle();
    check("hold_valid", out_valid, 1'b1);
    check("hold_pair", {grad_out1, grad_out2}, {32'h0, 32'h3F00_0000});
    check("hold_grad_ready", grad_ready, 1'b0);
    check("hold_count", idx_count, 5'd2);
    cycle(1'b0, 1'b0, 1'b1, 32'h1111_1111, ga, pa);
    check("hold_no_accept", ga, 1'b0);
    out_ready = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, 32'h0080_0000, ga, pa);
    check("release_accept1", ga, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h8000_0000, ga, pa);
    check("release_accept2", ga, 1'b1);
    idle();

    // Simultaneous push and pop at count 8
    for (int i = 0; i < 8; i++) push_bit(logic'(i[0]));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, logic'(i[1]), 1'b1, 32'h4200_0000 + i, ga, pa);
      check("simul_both", {ga, pa}, 2'b11);
      check("simul_count", idx_count, 5'd8);
    end
    for (int i = 0; i < 8; i++) send_grad(32'h7F80_0000 + i);
    idle();

    // Empty FIFO with a waiting gradient
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'hFF80_0000, ga, pa);
      check("empty_no_accept", ga, 1'b0);
      check("empty_no_valid", out_valid, 1'b0);
    end
    cycle(1'b1, 1'b1, 1'b1, 32'hFF80_0000, ga, pa);
    check("empty_push_same_cycle", {ga, pa}, 2'b01);
    cycle(1'b0, 1'b0, 1'b1, 32'hFF80_0000, ga, pa);
    check("empty_accept_next", ga, 1'b1);
    idle();

    // Flush mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_bit(logic'(i[0]));
    send_grad(32'h4040_0000);
    check("preflush_count", idx_count, 5'd5);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    sel_model.delete();
    check("flush_count", idx_count, 5'd0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", {idx_ready, grad_ready}, 2'b10);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) push_bit(1'b0);
    send_grad(32'hDEAD_BEEF);
    check("prerst_pair", {grad_out1, grad_out2}, {32'hDEAD_BEEF, 32'h0});
    #3 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_outs", {grad_out1, grad_out2}, 64'h0);
    check("arst_count", idx_count, 5'd0);
    exp_q.delete();
    sel_model.delete();
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    push_bit(1'b1);
    send_grad(32'h0000_0001);
    idle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
